raycast_host_master: RTL and testbench
======================================

// Module: raycast_host_master
// PURPOSE
// Wishbone initiator for the raycaster register block. On a go pulse it programs the four
// 32-bit configuration registers byte-wise and writes the start bit. It then polls the
// status register until the finished bit is set and reads back the cache hit/miss counters.
// It lets a hardware sequencer (or test harness) run a full frame without CPU involvement.
// PARAMETERS
// POLL_GAP     16   idle cycles between status polls (>=1)
// ACK_TIMEOUT  255  max cycles stb may wait for ack/err/rty before abort (>=2)
// PORTS
// wb_clk            in   1   clock
// wb_rst            in   1   synchronous reset, active-high
// wb_adr_o          out  8   register byte address
// wb_dat_o          out  8   write data
// wb_we_o           out  1   write enable
// wb_cyc_o          out  1   cycle valid
// wb_stb_o          out  1   strobe
// wb_cti_o          out  3   always 3'b000 (classic)
// wb_bte_o          out  2   always 2'b00
// wb_dat_i          in   8   read data
// wb_ack_i          in   1   transfer acknowledge
// wb_err_i          in   1   transfer error
// wb_rty_i          in   1   retry request
// go_i              in   1   start sequence (sampled only in IDLE)
// ray_buf_adr_i     in   32  value for regs 4..7
// ray_buf_count_i   in   32  value for regs 8..11
// octree_adr_i      in   32  value for regs 12..15
// fb_adr_i          in   32  value for regs 16..19
// busy_o            out  1   sequence in progress
// done_o            out  1   1-cycle pulse at sequence end (success or error)
// error_o           out  1   sticky error flag; cleared on next accepted go_i
// cache_hits_o      out  32  counter from regs 20..23, valid with done_o
// cache_miss_o      out  32  counter from regs 24..27, valid with done_o
// BEHAVIOUR
// - Reset: all outputs 0, FSM to IDLE. Reset mid-transfer drops cyc/stb at the next edge.
// - go_i in IDLE latches all four config inputs, clears error_o, sets busy_o. go_i while busy is ignored.
// - Transfer rules: cyc/stb/we/adr/dat are driven together and held stable until ack, err or rty
//   is sampled high. cyc/stb drop the cycle after that. There is exactly one idle cycle between
//   transfers. Read data is captured on the ack cycle.
//   With a 1-wait slave, each transfer takes 3 cycles.
// - FSM: IDLE -> CFG (16 writes, adr 4..19, each word MSB byte first: adr 4 = ray_buf_adr[31:24])
//   -> START (write adr 0, data 8'h01) -> POLL_WAIT (POLL_GAP idle cycles) -> POLL (read adr 1)
//   -> bit0=1: STATS; bit0=0: back to POLL_WAIT.
//   STATS (8 reads, adr 20..27, MSB first into shift regs) -> DONE (done_o=1 for 1 cycle,
//   cache_*_o updated) -> IDLE.
// - Reading adr 1 clears the slave status, so a single set bit0 is final. Do not re-read it.
// - rty: the same transfer is reissued after the idle cycle; the timeout counter keeps running across retries.
// - err or timeout (ACK_TIMEOUT cycles from the first stb of the transfer without ack): drop cyc.
//   Then set error_o, go to DONE (done_o pulses), and leave cache_*_o unchanged.
// - Timeout counter is 8 bits wide, saturating, and reset at each new transfer (not on rty).
// - Polling has no upper bound; a stuck raycaster is recovered only by wb_rst.
// - busy_o is high from the cycle after go is accepted through the DONE cycle inclusive.
// STRUCTURE
// - raycast_pkg: register address localparams (REG_CONTROL=0, REG_STATUS=1, REG_RAY_BUF_ADR=4,
//   REG_RAY_BUF_COUNT=8, REG_OCTREE_ADR=12, REG_FB_ADR=16, REG_CACHE_HITS=20, REG_CACHE_MISS=24),
//   CTRL_START=8'h01, and the FSM state encoding.
// - Sub-module raycast_wb_xfer: single-transfer engine. Inputs: req/we/adr/wdata.
//   Outputs: done/err/rdata. Owns the stb hold, rty reissue, idle gap and timeout.
//   The top level holds the sequencing FSM, byte index counter, poll counter and result registers.
// TESTING
// - Happy path, 1-wait slave: ray_buf_adr=32'h0500_0004, count=32'd307200.
//   Expect adr 4..7 data 05,00,00,04. Start write (adr 0, 01) at cycle 49 after go.
// - Finished after 3 polls: poll reads 00,00,01 spaced by POLL_GAP+3 cycles.
//   Hits=32'h1234_5678 and miss=32'h0000_00FF on adr 20..27 -> done_o=1 with those values, error_o=0.
// - Slave never acks during CFG: stb held for exactly ACK_TIMEOUT cycles, then cyc=0.
//   error_o=1, done_o pulses, cache_*_o unchanged.
// - rty on the adr 9 write: the same adr/data is reissued after 1 idle cycle; the sequence completes normally.
// - go_i pulsed during POLL: ignored, no extra transfers. wb_rst during STATS: cyc=0 next cycle, busy_o=0, all outputs 0.
// - err on the start write: error_o=1, no poll reads issued. The next go_i clears error_o and reruns cleanly.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared definitions for the raycaster host master: register map, control bits and FSM
// state encodings for the sequencer and the single-transfer engine.
package raycast_pkg;

  localparam logic [7:0] REG_CONTROL       = 8'd0;
  localparam logic [7:0] REG_STATUS        = 8'd1;
  localparam logic [7:0] REG_RAY_BUF_ADR   = 8'd4;
  localparam logic [7:0] REG_RAY_BUF_COUNT = 8'd8;
  localparam logic [7:0] REG_OCTREE_ADR    = 8'd12;
  localparam logic [7:0] REG_FB_ADR        = 8'd16;
  localparam logic [7:0] REG_CACHE_HITS    = 8'd20;
  localparam logic [7:0] REG_CACHE_MISS    = 8'd24;

  localparam logic [7:0] CTRL_START = 8'h01;

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StStart,
    StPollWait,
    StPoll,
    StStats,
    StDone
  } host_state_e;

  typedef enum logic [1:0] {
    XferIdle,
    XferBus,
    XferGap
  } xfer_state_e;

endpackage

// File: rtl/raycast_host_master_if.sv
// Wishbone classic bus between the raycaster host master and the register block slave.
interface raycast_host_master_if;

  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic       wb_we_o;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic       wb_err_i;
  logic       wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

endinterface

// File: rtl/raycast_wb_xfer.sv
// Single Wishbone classic transfer engine: holds the strobe until a response, reissues on
// retry after the idle cycle, and aborts with err_o after ACK_TIMEOUT cycles without ack.
module raycast_wb_xfer
  import raycast_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  raycast_host_master_if.master wb,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [7:0]            adr_i,
  input  logic [7:0]            wdata_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [7:0]            rdata_o
);

  localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

  xfer_state_e state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [7:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rty_q, rty_d;
  logic        resp;
  logic        timeout;

  always_comb begin
    resp    = wb.wb_ack_i | wb.wb_err_i | wb.wb_rty_i;
    timeout = (state_q == XferBus) && !resp && (cnt_q >= TimeoutLast);
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rty_d   = rty_q;
    // Saturating; keeps running through retry gaps so retries share one timeout budget.
    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    unique case (state_q)
      XferIdle, XferGap: begin
        if ((state_q == XferGap) && rty_q) begin
          state_d = XferBus;
          cyc_d   = 1'b1;
          rty_d   = 1'b0;
        end else if (req_i) begin
          state_d = XferBus;
          cyc_d   = 1'b1;
          we_d    = we_i;
          adr_d   = adr_i;
          dat_d   = wdata_i;
          cnt_d   = '0;
        end else begin
          state_d = XferIdle;
        end
      end
      XferBus: begin
        if (resp || timeout) begin
          state_d = XferGap;
          cyc_d   = 1'b0;
          rty_d   = wb.wb_rty_i & ~wb.wb_ack_i & ~wb.wb_err_i;
        end
      end
      default: state_d = XferIdle;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= XferIdle;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    done_o      = (state_q == XferBus) && wb.wb_ack_i;
    err_o       = (state_q == XferBus) && !wb.wb_ack_i && (wb.wb_err_i || timeout);
    rdata_o     = wb.wb_dat_i;
    wb.wb_cyc_o = cyc_q;
    wb.wb_stb_o = cyc_q;
    wb.wb_we_o  = we_q;
    wb.wb_adr_o = adr_q;
    wb.wb_dat_o = dat_q;
    wb.wb_cti_o = 3'b000;
    wb.wb_bte_o = 2'b00;
  end

endmodule

// File: rtl/raycast_host_master.sv
// Wishbone host sequencer for the raycaster: programs the config registers, starts a frame,
// polls for completion and reads back the cache hit/miss counters.
module raycast_host_master
  import raycast_pkg::*;
#(
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  raycast_host_master_if.master wb,
  input  logic                  go_i,
  input  logic [31:0]           ray_buf_adr_i,
  input  logic [31:0]           ray_buf_count_i,
  input  logic [31:0]           octree_adr_i,
  input  logic [31:0]           fb_adr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [31:0]           cache_hits_o,
  output logic [31:0]           cache_miss_o
);

  localparam int unsigned PollW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_GAP - 1);

  host_state_e      state_q, state_d;
  logic [3:0]       idx_q;
  logic [PollW-1:0] poll_cnt_q;
  logic [127:0]     cfg_q;
  logic [55:0]      stats_q;
  logic             error_q;
  logic [31:0]      hits_q, miss_q;

  logic       xfer_req, xfer_we, xfer_done, xfer_err;
  logic [7:0] xfer_adr, xfer_wdata, xfer_rdata;

  raycast_wb_xfer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xfer (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .wb     (wb),
    .req_i  (xfer_req),
    .we_i   (xfer_we),
    .adr_i  (xfer_adr),
    .wdata_i(xfer_wdata),
    .done_o (xfer_done),
    .err_o  (xfer_err),
    .rdata_o(xfer_rdata)
  );

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (go_i) state_d = StCfg;
      StCfg: begin
        if (xfer_err) state_d = StDone;
        else if (xfer_done && (idx_q == 4'd15)) state_d = StStart;
      end
      StStart: begin
        if (xfer_err) state_d = StDone;
        else if (xfer_done) state_d = StPollWait;
      end
      StPollWait: if (poll_cnt_q == PollLast) state_d = StPoll;
      StPoll: begin
        // The status read is destructive, so one set finished bit ends polling.
        if (xfer_err) state_d = StDone;
        else if (xfer_done) state_d = xfer_rdata[0] ? StStats : StPollWait;
      end
      StStats: begin
        if (xfer_err) state_d = StDone;
        else if (xfer_done && (idx_q == 4'd7)) state_d = StDone;
      end
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // The first config write is requested straight from the go cycle to save a cycle.
  always_comb begin
    xfer_req   = 1'b0;
    xfer_we    = 1'b0;
    xfer_adr   = '0;
    xfer_wdata = '0;
    unique case (state_q)
      StIdle: begin
        xfer_req   = go_i;
        xfer_we    = 1'b1;
        xfer_adr   = REG_RAY_BUF_ADR;
        xfer_wdata = ray_buf_adr_i[31:24];
      end
      StCfg: begin
        xfer_req   = 1'b1;
        xfer_we    = 1'b1;
        xfer_adr   = REG_RAY_BUF_ADR + {4'd0, idx_q};
        xfer_wdata = cfg_q[127:120];
      end
      StStart: begin
        xfer_req   = 1'b1;
        xfer_we    = 1'b1;
        xfer_adr   = REG_CONTROL;
        xfer_wdata = CTRL_START;
      end
      StPoll: begin
        xfer_req = 1'b1;
        xfer_adr = REG_STATUS;
      end
      StStats: begin
        xfer_req = 1'b1;
        xfer_adr = REG_CACHE_HITS + {4'd0, idx_q};
      end
      default: ;
    endcase
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
    error_o      = error_q;
    cache_hits_o = hits_q;
    cache_miss_o = miss_q;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      idx_q      <= '0;
      poll_cnt_q <= '0;
      cfg_q      <= '0;
      stats_q    <= '0;
      error_q    <= 1'b0;
      hits_q     <= '0;
      miss_q     <= '0;
    end else begin
      if ((state_q != StCfg) && (state_q != StStats)) idx_q <= '0;
      else if (xfer_done) idx_q <= idx_q + 4'd1;

      if (state_q == StPollWait) poll_cnt_q <= poll_cnt_q + 1'b1;
      else poll_cnt_q <= '0;

      if ((state_q == StIdle) && go_i) begin
        cfg_q   <= {ray_buf_adr_i, ray_buf_count_i, octree_adr_i, fb_adr_i};
        error_q <= 1'b0;
      end else if ((state_q == StCfg) && xfer_done) begin
        cfg_q <= {cfg_q[119:0], 8'h00};
      end

      if (xfer_err) error_q <= 1'b1;

      if ((state_q == StStats) && xfer_done) begin
        stats_q <= {stats_q[47:0], xfer_rdata};
        if (idx_q == 4'd7) begin
          hits_q <= stats_q[55:24];
          miss_q <= {stats_q[23:0], xfer_rdata};
        end
      end
    end
  end

endmodule

// File: tb/tb_raycast_host_master.sv
// Scoreboard bench for raycast_host_master with a 1-wait Wishbone slave model that can
// withhold ack, retry the adr 9 write, or error the start write.
module tb_raycast_host_master;

  localparam int unsigned PollGap    = 16;
  localparam int unsigned AckTimeout = 255;

  typedef struct {
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
    int         start;
  } xfer_t;

  typedef struct {
    logic        err;
    logic [31:0] hits;
    logic [31:0] miss;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [31:0] ray_buf_adr = '0, ray_buf_count = '0, octree_adr = '0, fb_adr = '0;
  logic        busy, done, error;
  logic [31:0] cache_hits, cache_miss;

  raycast_host_master_if bus ();

  raycast_host_master #(
    .POLL_GAP   (PollGap),
    .ACK_TIMEOUT(AckTimeout)
  ) dut (
    .wb_clk         (clk),
    .wb_rst         (rst),
    .wb             (bus),
    .go_i           (go),
    .ray_buf_adr_i  (ray_buf_adr),
    .ray_buf_count_i(ray_buf_count),
    .octree_adr_i   (octree_adr),
    .fb_adr_i       (fb_adr),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .cache_hits_o   (cache_hits),
    .cache_miss_o   (cache_miss)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Slave model: registered responses, one wait state.
  logic        ack_r = 1'b0, err_r = 1'b0, rty_r = 1'b0;
  logic [7:0]  rdat_r = '0;
  logic        slv_noack = 1'b0, slv_err_ctrl = 1'b0;
  int          rty_limit = 0, rty_cnt = 0;
  logic [31:0] stat_hits = '0, stat_miss = '0;
  logic [7:0]  status_q[$];

  assign bus.wb_ack_i = ack_r;
  assign bus.wb_err_i = err_r;
  assign bus.wb_rty_i = rty_r;
  assign bus.wb_dat_i = rdat_r;

  function automatic logic [7:0] stat_byte(input logic [7:0] a, input logic [63:0] v);
    logic [63:0] sh;
    if (a < 8'd20 || a > 8'd27) return 8'h00;
    sh = v >> (8 * (27 - int'(a)));
    return sh[7:0];
  endfunction

  always @(posedge clk) begin
    ack_r <= 1'b0;
    err_r <= 1'b0;
    rty_r <= 1'b0;
    if (bus.wb_cyc_o && bus.wb_stb_o && !(ack_r || err_r || rty_r) && !slv_noack) begin
      if (bus.wb_we_o && bus.wb_adr_o == 8'd9 && rty_cnt < rty_limit) begin
        rty_r   <= 1'b1;
        rty_cnt <= rty_cnt + 1;
      end else if (bus.wb_we_o && bus.wb_adr_o == 8'd0 && slv_err_ctrl) begin
        err_r <= 1'b1;
      end else begin
        ack_r <= 1'b1;
        if (!bus.wb_we_o && bus.wb_adr_o == 8'd1)
          rdat_r <= (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
        else
          rdat_r <= stat_byte(bus.wb_adr_o, {stat_hits, stat_miss});
      end
    end
  end

  // Scoreboard monitor.
  xfer_t exp_q[$];
  done_t exp_done_q[$];
  logic  stb_prev = 1'b0;
  int    stb_start = 0;

  task automatic mon_xfer();
    xfer_t e;
    if (exp_q.size() == 0) begin
      check("xfer_unexpected", {56'd0, bus.wb_adr_o}, 64'hFFFF);
    end else begin
      e = exp_q.pop_front();
      check("xfer_adr", bus.wb_adr_o, e.adr);
      check("xfer_we", bus.wb_we_o, e.we);
      if (e.we) check("xfer_dat", bus.wb_dat_o, e.dat);
      if (e.start >= 0) check("xfer_start_cycle", stb_start, e.start);
    end
  endtask

  task automatic mon_done();
    done_t d;
    if (exp_done_q.size() == 0) begin
      check("done_unexpected", done, 1'b0);
    end else begin
      d = exp_done_q.pop_front();
      check("done_error", error, d.err);
      check("done_hits", cache_hits, d.hits);
      check("done_miss", cache_miss, d.miss);
      check("done_busy", busy, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_stb_o && !stb_prev) stb_start <= cyc_cnt;
    stb_prev <= bus.wb_stb_o;
    if (!rst && bus.wb_stb_o && (ack_r || err_r || rty_r)) mon_xfer();
    if (done) mon_done();
  end

  // Stimulus helpers.
  task automatic push_x(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                        input int start);
    exp_q.push_back('{we, adr, dat, start});
  endtask

  task automatic push_run(input int n0, input bit rty9, input int npolls, input bit err_start);
    logic [127:0] cfg, sh;
    int s, sw, p;
    cfg = {ray_buf_adr, ray_buf_count, octree_adr, fb_adr};
    for (int k = 0; k < 16; k++) begin
      sh = cfg >> (8 * (15 - k));
      s  = n0 + 1 + 3 * k + ((rty9 && k > 5) ? 3 : 0);
      if (rty9 && k == 5) begin
        push_x(1'b1, 8'(4 + k), sh[7:0], s);
        push_x(1'b1, 8'(4 + k), sh[7:0], s + 3);
      end else begin
        push_x(1'b1, 8'(4 + k), sh[7:0], s);
      end
    end
    sw = n0 + 49 + (rty9 ? 3 : 0);
    push_x(1'b1, 8'd0, 8'h01, sw);
    if (!err_start) begin
      p = sw;
      for (int i = 0; i < npolls; i++) begin
        p += PollGap + 3;
        push_x(1'b0, 8'd1, 8'h00, p);
        status_q.push_back((i == npolls - 1) ? 8'h01 : 8'h00);
      end
      for (int j = 0; j < 8; j++) push_x(1'b0, 8'(20 + j), 8'h00, p + 3 + 3 * j);
    end
  endtask

  task automatic go_begin(output int n0);
    @(posedge clk);
    #1;
    go = 1'b1;
    n0 = cyc_cnt;
  endtask

  task automatic go_end();
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n0, len, w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_stb", bus.wb_stb_o, 0);
    check("rst_adr_dat_we", {bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o}, 0);
    check("rst_cti_bte", {bus.wb_cti_o, bus.wb_bte_o}, 0);
    check("rst_cache", {cache_hits, cache_miss}, 0);

    // Happy path, finished on the third poll; a go pulse during polling must be ignored.
    ray_buf_adr = 32'h0500_0004; ray_buf_count = 32'd307200;
    octree_adr = 32'h1000_2000; fb_adr = 32'hA0B0_C0D0;
    stat_hits = 32'h1234_5678; stat_miss = 32'h0000_00FF;
    go_begin(n0);
    push_run(n0, 1'b0, 3, 1'b0);
    exp_done_q.push_back('{1'b0, 32'h1234_5678, 32'h0000_00FF});
    go_end();
    check("busy_after_go", busy, 1'b1);
    while (cyc_cnt < n0 + 75) @(posedge clk);
    #1 go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    wait_idle(2000);

    // Slave never acks: stb held for the full timeout, cache left alone.
    slv_noack = 1'b1;
    exp_done_q.push_back('{1'b1, 32'h1234_5678, 32'h0000_00FF});
    go_begin(n0);
    go_end();
    len = 0;
    w = 0;
    @(negedge clk);
    while (!bus.wb_stb_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    while (bus.wb_stb_o && len < 400) begin
      len++;
      @(negedge clk);
    end
    check("timeout_stb_len", len, AckTimeout);
    check("timeout_cyc_dropped", bus.wb_cyc_o, 1'b0);
    wait_idle(500);
    slv_noack = 1'b0;

    // Retry on the adr 9 write; also shows error_o clears on go.
    ray_buf_adr = 32'h0102_0304; ray_buf_count = 32'h5566_7788;
    octree_adr = 32'h99AA_BBCC; fb_adr = 32'hDDEE_FF00;
    stat_hits = 32'hDEAD_BEEF; stat_miss = 32'h0000_0001;
    rty_limit = 1;
    go_begin(n0);
    push_run(n0, 1'b1, 1, 1'b0);
    exp_done_q.push_back('{1'b0, 32'hDEAD_BEEF, 32'h0000_0001});
    go_end();
    check("error_cleared_by_go", error, 1'b0);
    wait_idle(2000);

    // Error on the start write: no polls, cache unchanged; then a clean rerun.
    slv_err_ctrl = 1'b1;
    stat_hits = 32'h0000_0100; stat_miss = 32'h8000_0000;
    go_begin(n0);
    push_run(n0, 1'b0, 0, 1'b1);
    exp_done_q.push_back('{1'b1, 32'hDEAD_BEEF, 32'h0000_0001});
    go_end();
    wait_idle(2000);
    slv_err_ctrl = 1'b0;
    go_begin(n0);
    push_run(n0, 1'b0, 2, 1'b0);
    exp_done_q.push_back('{1'b0, 32'h0000_0100, 32'h8000_0000});
    go_end();
    check("rerun_error_cleared", error, 1'b0);
    wait_idle(2000);

    // Reset while reading the stats counters.
    go_begin(n0);
    push_run(n0, 1'b0, 1, 1'b0);
    go_end();
    w = 0;
    while (!(bus.wb_stb_o && bus.wb_adr_o == 8'd22) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("stats_reached", bus.wb_adr_o, 8'd22);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_cyc", bus.wb_cyc_o, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_flags", {done, error}, 2'b00);
    check("rst_mid_cache", {cache_hits, cache_miss}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    status_q.delete();
    repeat (5) @(negedge clk);
    check("rst_mid_stays_idle", {busy, bus.wb_cyc_o}, 2'b00);

    check("exp_xfer_drained", exp_q.size(), 0);
    check("exp_done_drained", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
